// File: rtl/ift_sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM (1-cycle read latency), with taint shadows.
// Optional build macro IFT_ARB_IMPLICIT_EN adds implicit-flow taint from the grant/owner decision.
module ift_sram_arbiter #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  localparam int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [1:0]                       p_req_i,
  input  logic [1:0]                       p_req_i_t0,
  input  logic [1:0]                       p_we_i,
  input  logic [1:0]                       p_we_i_t0,
  input  logic [1:0][AddrWidth-1:0]        p_addr_i,
  input  logic [1:0][AddrWidth-1:0]        p_addr_i_t0,
  input  logic [1:0][StrbWidth-1:0]        p_be_i,
  input  logic [1:0][StrbWidth-1:0]        p_be_i_t0,
  input  logic [1:0][DataWidth-1:0]        p_wdata_i,
  input  logic [1:0][DataWidth-1:0]        p_wdata_i_t0,
  output logic [1:0]                       p_gnt_o,
  output logic [1:0]                       p_gnt_o_t0,
  output logic [1:0]                       p_rvalid_o,
  output logic [1:0]                       p_rvalid_o_t0,
  output logic [1:0][DataWidth-1:0]        p_rdata_o,
  output logic [1:0][DataWidth-1:0]        p_rdata_o_t0,
  output logic                             m_req_o,
  output logic                             m_req_o_t0,
  output logic                             m_we_o,
  output logic                             m_we_o_t0,
  output logic [AddrWidth-1:0]             m_addr_o,
  output logic [AddrWidth-1:0]             m_addr_o_t0,
  output logic [StrbWidth-1:0]             m_be_o,
  output logic [StrbWidth-1:0]             m_be_o_t0,
  output logic [DataWidth-1:0]             m_wdata_o,
  output logic [DataWidth-1:0]             m_wdata_o_t0,
  input  logic [DataWidth-1:0]             m_rdata_i,
  input  logic [DataWidth-1:0]             m_rdata_i_t0
);

  logic rr_q;        // port favoured on contention
  logic owner_q;     // port owning the response in flight
  logic rvalid_q;    // a response is due this cycle
  logic req_t0_q;    // registered m_req_o_t0

  logic any_c;
  logic both_c;
  logic win_c;

`ifdef IFT_ARB_IMPLICIT_EN
  logic sel_t0_q;
  logic sel_t0_c;
`endif

  // Winner selection; nothing is granted while reset is asserted.
  always_comb begin
    any_c  = (|p_req_i) & ~rst_i;
    both_c = (&p_req_i) & ~rst_i;
    win_c  = both_c ? rr_q : p_req_i[1];
  end

  // Forward the winner's request and taint to the SRAM.
  always_comb begin
    m_req_o      = 1'b0;
    m_req_o_t0   = 1'b0;
    m_we_o       = 1'b0;
    m_we_o_t0    = 1'b0;
    m_addr_o     = '0;
    m_addr_o_t0  = '0;
    m_be_o       = '0;
    m_be_o_t0    = '0;
    m_wdata_o    = '0;
    m_wdata_o_t0 = '0;
    p_gnt_o      = 2'b00;
    if (any_c) begin
      m_req_o         = 1'b1;
      m_req_o_t0      = p_req_i_t0[win_c];
      m_we_o          = p_we_i[win_c];
      m_we_o_t0       = p_we_i_t0[win_c];
      m_addr_o        = p_addr_i[win_c];
      m_addr_o_t0     = p_addr_i_t0[win_c];
      m_be_o          = p_be_i[win_c];
      m_be_o_t0       = p_be_i_t0[win_c];
      m_wdata_o       = p_wdata_i[win_c];
      m_wdata_o_t0    = p_wdata_i_t0[win_c];
      p_gnt_o[win_c]  = 1'b1;
    end
  end

  // Grant taint: implicit mode lets either requester's taint reach both grants under contention.
  always_comb begin
`ifdef IFT_ARB_IMPLICIT_EN
    sel_t0_c   = both_c & (|p_req_i_t0);
    p_gnt_o_t0 = rst_i ? 2'b00 : (both_c ? {2{|p_req_i_t0}} : p_req_i_t0);
`else
    p_gnt_o_t0 = p_req_i_t0 & p_gnt_o;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      rvalid_q <= 1'b0;
      req_t0_q <= 1'b0;
`ifdef IFT_ARB_IMPLICIT_EN
      sel_t0_q <= 1'b0;
`endif
    end else begin
      rvalid_q <= any_c;
      req_t0_q <= m_req_o_t0;
`ifdef IFT_ARB_IMPLICIT_EN
      sel_t0_q <= sel_t0_c;
`endif
      if (any_c) begin
        owner_q <= win_c;
        rr_q    <= ~win_c;
      end
    end
  end

  // Route the SRAM response back to the owner only.
  always_comb begin
    p_rvalid_o    = 2'b00;
    p_rvalid_o_t0 = 2'b00;
    p_rdata_o     = '0;
    p_rdata_o_t0  = '0;
    if (rvalid_q) begin
      p_rvalid_o[owner_q] = 1'b1;
      p_rdata_o[owner_q]  = m_rdata_i;
`ifdef IFT_ARB_IMPLICIT_EN
      p_rvalid_o_t0[owner_q] = req_t0_q | sel_t0_q;
      p_rdata_o_t0[owner_q]  = m_rdata_i_t0 | {DataWidth{sel_t0_q}};
`else
      p_rvalid_o_t0[owner_q] = req_t0_q;
      p_rdata_o_t0[owner_q]  = m_rdata_i_t0;
`endif
    end
  end

endmodule
